// File: rtl/serial_lg_unit.sv
// serial_lg_unit: bit-serial bitwise logic unit (AND / OR / NOT A / XOR).
//
// Handshake in, handshake out. One accepted operation is processed one bit
// per clock, LSB first, and the result is published all at once on entry
// to DONE.
//
// Ports:
//   clk        clock, rising edge active
//   rst        asynchronous active-high reset
//   in_valid   requester presents an operation
//   in_ready   block can accept an operation (IDLE)
//   a, b       operands, WIDTH bits
//   s1, s0     op select: 00 AND, 01 OR, 10 NOT A, 11 XOR
//   out_valid  f and z hold a completed result (DONE)
//   out_ready  consumer takes the result
//   f          result, WIDTH bits
//   z          1 when f is all zeros
//   busy       operation in progress (SHIFT)
module serial_lg_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s1,
    input  logic             s0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             z,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic             z_q, z_d;

    logic             res_bit;
    logic [WIDTH-1:0] acc_next;
    logic             last;

    // Captured operands are shifted right each SHIFT cycle, so bit 0 is
    // always the current bit; avoids a variable-index mux.
    always_comb begin
        res_bit = 1'b0;
        unique case (op_q)
            2'b00: res_bit = a_q[0] & b_q[0];
            2'b01: res_bit = a_q[0] | b_q[0];
            2'b10: res_bit = ~a_q[0];
            2'b11: res_bit = a_q[0] ^ b_q[0];
            default: res_bit = 1'b0;
        endcase
    end

    // New bit enters at the MSB; after WIDTH shifts the first bit sits at bit 0.
    assign acc_next = {res_bit, acc_q[WIDTH-1:1]};
    assign last     = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        acc_d   = acc_q;
        f_d     = f_q;
        z_d     = z_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = {s1, s0};
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                acc_d = acc_next;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    f_d     = acc_next;
                    z_d     = ~|acc_next;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            f_q     <= '0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            f_q     <= f_d;
            z_q     <= z_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q == StShift);
    assign out_valid = (state_q == StDone);
    assign f         = f_q;
    assign z         = z_q;

endmodule

// File: doc/serial_lg_unit.md
SERIAL_LG_UNIT -- requirements
Module: serial_lg_unit

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  requester presents an operation.
REQ-005 in_ready  output  1  block can accept an operation.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 s1, s0  input  1 each  operation select.
REQ-009 out_valid  output  1  f and z hold a completed result.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 f  output  WIDTH  result.
REQ-012 z  output  1  zero flag; 1 when f is all zeros.
REQ-013 busy  output  1  operation in progress (state SHIFT).

Function
REQ-014 The op select SHALL be: 00 AND, 01 OR, 10 NOT A (B ignored), 11 XOR, applied bitwise.
REQ-015 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; busy SHALL be 1 only in SHIFT; out_valid SHALL be 1 only in DONE; all three are decoded from registered state.
REQ-017 Accept: an edge with in_valid=1 and in_ready=1 SHALL capture a, b and {s1,s0}, clear the bit counter, and enter SHIFT; later changes on a, b and s1/s0 SHALL NOT affect that operation.
REQ-018 In SHIFT, each edge SHALL compute exactly one result bit, LSB first, from the captured operands and op, then increment the counter.
REQ-019 After the WIDTH-th SHIFT edge, the block SHALL load f with the assembled result, load z with the NOR of all result bits, and enter DONE.
REQ-020 Latency: with an accept on edge E0, out_valid SHALL rise after edge E0+WIDTH (8 cycles for WIDTH=8).
REQ-021 In DONE, f, z and out_valid SHALL hold stable until an edge with out_ready=1; that edge SHALL return the FSM to IDLE.
REQ-022 out_ready SHALL be ignored outside DONE, and in_valid SHALL be ignored outside IDLE (no back-to-back overlap); the minimum accept-to-accept spacing SHALL be WIDTH+2 cycles.
REQ-023 f and z SHALL change only on the transition into DONE or on reset, never during SHIFT; partial results SHALL NOT be visible.
REQ-024 After the return to IDLE, f and z SHALL keep the last result.
REQ-025 If out_ready is 1 on the same edge the block enters DONE, the block SHALL still spend at least one cycle in DONE with out_valid=1.
REQ-026 The bit counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL NOT wrap within an operation.

Reset
REQ-027 rst=1 SHALL immediately, without a clock edge, force state IDLE, counter 0, f=0, z=0, out_valid=0 and busy=0, and clear the captured operands.
REQ-028 While rst=1, in_ready SHALL be 1.
REQ-029 A reset asserted in SHIFT or DONE SHALL abort the operation; no out_valid pulse SHALL follow the deassertion.
REQ-030 The first accept SHALL be possible on the first edge after rst deasserts.

Verification
REQ-031 WIDTH=8, a=0xF0, b=0x3C, op=00, out_ready=1 -> out_valid after 8 cycles, f=0x30, z=0.
REQ-032 a=0x0F, b=0xF0, op=00 -> f=0x00, z=1; a=0xFF, op=10 -> f=0x00, z=1; a=0xA5, b=0x5A, op=11 -> f=0xFF, z=0.
REQ-033 Hold out_ready=0 for 5 cycles in DONE -> f, z and out_valid stable throughout, in_ready=0; a new in_valid pulse in that window is not accepted.
REQ-034 Change a/b/op during SHIFT -> the result matches the values captured at accept.
REQ-035 Assert rst at SHIFT cycle 4 -> f=0, z=0, out_valid=0 and in_ready=1 immediately, and no later out_valid; a new op (a=0x12, b=0x34, op=01) -> f=0x36.
REQ-036 Two ops back-to-back with in_valid held high and out_ready=1 -> the second op is accepted on the first edge after the DONE handshake; results are correct and in order.
